mem_loader: RTL and testbench

//  Bus initiator that fills the 64x9 program memory from a streamed word source, then

---
 rtl/mem_loader.sv | 138 +++++++++++++
 tb/tb_mem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Bus initiator: streams LOAD_WORDS words into program memory, optionally reads them
// back and compares checksums, then releases the memory bus to the CPU.
module mem_loader #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 9,
  parameter int unsigned LOAD_WORDS = 64,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          READ,
  output logic          WRITE,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DATA,
  input  logic [DW-1:0] D,
  output logic          hold_cpu,
  output logic          done,
  output logic          error
);

  localparam logic [AW-1:0] LastAddr = AW'(LOAD_WORDS - 1);

  typedef enum logic [3:0] {
    StIdle, StWait, StWsetup, StWstrobe, StWhold,
    StRsetup, StRsample, StCheck, StDone, StError
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   wsum_q, wsum_d;
  logic [15:0]   rsum_q, rsum_d;
  logic          in_ready_q, read_q, write_q, hold_q, done_q, error_q;

  // Next-state, address counter, bus address/data and checksum updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    a_d     = a_q;
    data_d  = data_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StWait;
          addr_d  = '0;
          wsum_d  = '0;
          rsum_d  = '0;
        end
      end
      StWait: begin
        // in_ready_q is high exactly while in this state
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          a_d     = addr_q;
          wsum_d  = wsum_q + 16'(in_data);
          state_d = StWsetup;
        end
      end
      StWsetup:  state_d = StWstrobe;
      StWstrobe: state_d = StWhold;
      StWhold: begin
        if (addr_q == LastAddr) begin
          if (VERIFY) begin
            addr_d  = '0;
            a_d     = '0;
            state_d = StRsetup;
          end else begin
            state_d = StDone;
          end
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StWait;
        end
      end
      StRsetup: state_d = StRsample;
      StRsample: begin
        rsum_d = rsum_q + 16'(D);
        if (addr_q == LastAddr) begin
          state_d = StCheck;
        end else begin
          addr_d  = addr_q + 1'b1;
          a_d     = addr_q + 1'b1;
          state_d = StRsetup;
        end
      end
      StCheck: state_d = (rsum_q == wsum_q) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      a_q        <= '0;
      data_q     <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      in_ready_q <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      a_q        <= a_d;
      data_q     <= data_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      in_ready_q <= (state_d == StWait);
      read_q     <= (state_d == StRsetup) || (state_d == StRsample);
      write_q    <= (state_d == StWstrobe);
      hold_q     <= (state_d != StIdle) && (state_d != StDone);
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StError);
    end
  end

  assign in_ready = in_ready_q;
  assign READ     = read_q;
  assign WRITE    = write_q;
  assign A        = a_q;
  assign DATA     = data_q;
  assign hold_cpu = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: memory model, write scoreboard, bus protocol checks.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready, READ, WRITE, hold_cpu, done, error;
  logic [8:0] in_data, DATA, D;
  logic [5:0] A;

  logic       s_start, s_in_valid, s_in_ready, s_READ, s_WRITE, s_hold_cpu, s_done, s_error;
  logic [8:0] s_in_data, s_DATA, s_D;
  logic [5:0] s_A;

  logic [8:0]  mem [64];
  logic [8:0]  mem2 [64];
  logic        clr, corrupt;
  logic [14:0] sb [$];
  logic [5:0]  addr_exp;
  logic        write_prev;
  logic [5:0]  prev_a;
  logic [8:0]  prev_d;
  int          n_writes, n_reads, s_writes, s_reads;
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .READ(READ), .WRITE(WRITE), .A(A), .DATA(DATA), .D(D),
    .hold_cpu(hold_cpu), .done(done), .error(error)
  );

  mem_loader #(.AW(6), .DW(9), .LOAD_WORDS(1), .VERIFY(1'b0)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .READ(s_READ), .WRITE(s_WRITE), .A(s_A), .DATA(s_DATA), .D(s_D),
    .hold_cpu(s_hold_cpu), .done(s_done), .error(s_error)
  );

  // Memory models; word 17 of the main memory optionally reads back corrupted.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= '0;
        mem2[i] <= '0;
      end
    end else begin
      if (WRITE)   mem[A]    <= DATA;
      if (s_WRITE) mem2[s_A] <= s_DATA;
    end
  end
  assign D   = mem[A] ^ {8'h00, (corrupt && A == 6'd17)};
  assign s_D = mem2[s_A];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard pop, strobe width/stability and bus-protocol checks.
  always @(negedge clk) begin
    logic [14:0] e;
    if (write_prev) begin
      chk("write_width", WRITE, 0);
      chk("a_hold", A, prev_a);
      chk("data_hold", DATA, prev_d);
    end
    if (WRITE) begin
      n_writes++;
      chk("a_setup", A, prev_a);
      chk("data_setup", DATA, prev_d);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_addr", A, e[14:9]);
        chk("write_data", DATA, e[8:0]);
      end
    end
    if (READ) n_reads++;
    if (s_WRITE) s_writes++;
    if (s_READ) s_reads++;
    write_prev = WRITE;
    prev_a     = A;
    prev_d     = DATA;
    chk("rw_excl", READ && WRITE, 0);
    chk("strobe_unheld", (READ || WRITE) && !hold_cpu, 0);
    chk("a_range", A < 64, 1);
    chk("s_rw_excl", s_READ && s_WRITE, 0);
    chk("s_strobe_unheld", (s_READ || s_WRITE) && !s_hold_cpu, 0);
    chk("s_a_range", s_A, 0);
  end

  task automatic send(input logic [8:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_timeout", n < 40, 1);
    sb.push_back({addr_exp, w});
    addr_exp = addr_exp + 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr_exp = '0;
  endtask

  task automatic load(input bit gapped);
    int n;
    pulse_start();
    chk("hold_during_load", hold_cpu, 1);
    for (int i = 0; i < 64; i++) send(9'(i), gapped ? int'($urandom_range(5, 0)) : 0);
    in_valid = 1'b0;
    n = 0;
    while (!(done || error) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", n < 400, 1);
  endtask

  task automatic chk_image();
    for (int i = 0; i < 64; i++) chk("mem_image", mem[i], i);
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
    clr = 1'b0; corrupt = 1'b0; addr_exp = '0; write_prev = 1'b0; prev_a = '0; prev_d = '0;
    n_writes = 0; n_reads = 0; s_writes = 0; s_reads = 0;
    clear_mem();
    @(negedge clk);
    chk("rst_hold", hold_cpu, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_a", A, 0);
    chk("rst_data", DATA, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream of 0..63
    n_writes = 0;
    load(1'b0);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_hold", hold_cpu, 0);
    chk("t1_writes", n_writes, 64);
    chk("t1_sb_empty", sb.size(), 0);
    chk_image();

    // Gapped stream into a cleared memory
    clear_mem();
    n_writes = 0;
    load(1'b1);
    chk("t2_done", done, 1);
    chk("t2_writes", n_writes, 64);
    chk("t2_sb_empty", sb.size(), 0);
    chk_image();

    // Corrupted read-back of word 17, then clean retry
    corrupt = 1'b1;
    load(1'b0);
    chk("t3_error", error, 1);
    chk("t3_done", done, 0);
    chk("t3_hold", hold_cpu, 1);
    repeat (10) @(negedge clk);
    chk("t3_hold_kept", hold_cpu, 1);
    chk("t3_error_kept", error, 1);
    corrupt = 1'b0;
    load(1'b0);
    chk("t3_retry_done", done, 1);
    chk("t3_retry_error", error, 0);
    chk("t3_retry_hold", hold_cpu, 0);

    // Reset during the write strobe of word 5
    clear_mem();
    pulse_start();
    for (int i = 0; i < 6; i++) send(9'(i + 100), 0);
    @(posedge clk);
    #1;
    chk("t4_in_strobe", WRITE, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_write", WRITE, 0);
    chk("t4_rst_read", READ, 0);
    chk("t4_rst_hold", hold_cpu, 0);
    chk("t4_rst_ready", in_ready, 0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_idle_hold", hold_cpu, 0);
    chk("t4_idle_ready", in_ready, 0);
    chk("t4_idle_done", done, 0);
    chk("t4_idle_a", A, 0);
    load(1'b0);
    chk("t4_reload_done", done, 1);
    chk("t4_sb_empty", sb.size(), 0);
    chk_image();

    // Single word, no verify
    s_writes = 0;
    s_reads = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_in_data = 9'h1FF;
    n = 0;
    while (s_in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_xfer_timeout", n < 40, 1);
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_write", s_WRITE, 1);
    chk("t5_a", s_A, 0);
    chk("t5_data", s_DATA, 9'h1FF);
    @(negedge clk);
    chk("t5_not_done_yet", s_done, 0);
    @(negedge clk);
    chk("t5_done", s_done, 1);
    chk("t5_hold", s_hold_cpu, 0);
    chk("t5_writes", s_writes, 1);
    chk("t5_reads", s_reads, 0);
    chk("t5_mem", mem2[0], 9'h1FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
